spi_word_xfer: RTL and testbench
================================

// Module: spi_word_xfer
// PURPOSE
//  SPI mode-0 master sitting directly downstream of a word fifo. It pops one
//  word per frame from the fifo's unbuffered output, shifts it out MSB-first
//  on mosi and shifts miso in on the same frame. The received word goes to a
//  second (rx) fifo through a single-cycle write strobe.
//  Only one word is in flight at a time.
// PARAMETERS
//  WIDTH   16  word width in bits; equals the SPI frame length
//  CLKDIV  2   clk cycles per sclk half-period (>=1)
//  GAP     2   clk cycles ss_n is held high between frames (>=1)
// PORTS
//  clk     in   1      system clock; all state on posedge
//  rst_n   in   1      reset, asynchronous, active-low
//  d       in   WIDTH  tx word, connected to the tx fifo q (valid while ~empty)
//  empty   in   1      tx fifo empty
//  rd      out  1      tx fifo pop; one-cycle pulse
//  rxd     out  WIDTH  last received word; stable between rxwr pulses
//  rxwr    out  1      rx fifo write strobe; one-cycle pulse
//  rxfull  in   1      rx fifo full
//  sclk    out  1      SPI clock; idles low
//  mosi    out  1      SPI data out
//  miso    in   1      SPI data in
//  ss_n    out  1      slave select, active-low
//  busy    out  1      high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0) forces state IDLE and:
//    ss_n=1, sclk=0, mosi=0, rd=0, rxwr=0, rxd=0, busy=0; counters 0.
//  - All outputs are registered.
//  - FSM states: IDLE, SETUP, HIGH, LOW, GAP.
//  - IDLE: when ~empty & ~rxfull, the next edge does all of the following:
//    latch tx shift reg <= d; rd=1 for exactly that cycle; ss_n<=0;
//    mosi<=d[WIDTH-1]; enter SETUP. rd is never asserted while empty.
//  - SETUP: CLKDIV cycles with sclk=0; then sclk<=1 and enter HIGH.
//    On the edge that drives sclk 0->1, capture miso into the rx shift reg LSB
//    (shift left).
//  - HIGH: CLKDIV cycles; then sclk<=0 and enter LOW.
//    If bits remain, shift tx reg and drive the next bit on mosi at that edge.
//  - LOW: CLKDIV cycles. Then, if bitcnt < WIDTH, sclk<=1 (miso capture as
//    above) and enter HIGH. Otherwise ss_n<=1, rxwr=1 for one cycle,
//    rxd<=rx shift reg, mosi<=0, enter GAP.
//  - GAP: GAP cycles with ss_n=1, then IDLE. The earliest next rd follows
//    on the IDLE->start edge.
//  - Timing: ss_n low for exactly CLKDIV*(2*WIDTH+1) cycles.
//    Frame-to-frame period = CLKDIV*(2*WIDTH+1) + GAP + 1 cycles.
//  - Counters: divcnt is $clog2(CLKDIV+1) bits; bitcnt is $clog2(WIDTH+1)
//    bits, counting rising sclk edges. Both clear on entering SETUP.
//  - empty / rxfull are looked at only in IDLE; changes mid-frame are ignored.
//    rxfull=0 at start guarantees rx space, since this block is the rx fifo's
//    only writer.
//  - Reset mid-frame: frame aborted immediately, no rxwr. The popped tx word
//    is discarded; the next frame starts from IDLE with the next fifo word.
// STRUCTURE
//  - State encodings and counter widths are module-local localparams.
//    No shared package is needed.
//  - One sub-module: spi_tick. It is the CLKDIV half-period strobe counter
//    (clk, rst_n, clr, tick); reusable by the rx-side SPI slave.
// TESTING (WIDTH=16, CLKDIV=2, GAP=2 unless noted; miso looped to mosi)
//  1. Reset:
//     rst_n=0 for 3 cycles -> ss_n=1, sclk=0, mosi=0, rd=0, rxwr=0, busy=0.
//  2. Single word:
//     - Stimulus: fifo holds 16'hA5C3.
//     - rd pulses 1 cycle and ss_n falls on the same edge.
//     - mosi at the 16 rising sclk edges = 1010_0101_1100_0011.
//     - ss_n low for 66 cycles; rxwr one cycle with rxd=16'hA5C3.
//  3. Back-to-back:
//     - Stimulus: fifo holds 16'h0001, 16'h8000.
//     - ss_n high exactly 3 cycles between frames; rd pulses 69 cycles apart.
//     - rxd values 16'h0001 then 16'h8000.
//  4. Flow control:
//     - Stimulus: rxfull=1 with empty=0 for 20 cycles.
//     - No rd; ss_n stays 1.
//     - After rxfull drops: rd on the next edge, frame starts.
//  5. Reset mid-frame: rst_n low after the 8th rising sclk edge.
//     - ss_n=1 and sclk=0 without waiting for clk; no rxwr.
//     - After release, the next fifo word transfers intact.
//  6. CLKDIV=1, WIDTH=8, GAP=1, word 8'h3C:
//     - sclk period 2 cycles; ss_n low 17 cycles.
//     - mosi = 0011_1100; rxd=8'h3C.

Source files
------------

// File: rtl/spi_tick.sv
// Half-period strobe for SPI timing: tick is high on every CLKDIV-th cycle after clr drops.
module spi_tick #(
    parameter int unsigned CLKDIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLKDIV > 1) ? $clog2(CLKDIV + 1) : 1;
    localparam logic [CW-1:0] DivLast = CW'(CLKDIV - 1);

    logic [CW-1:0] divcnt_q;

    assign tick = (divcnt_q == DivLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divcnt_q <= '0;
        end else if (clr || tick) begin
            divcnt_q <= '0;
        end else begin
            divcnt_q <= divcnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spi_word_xfer.sv
// SPI mode-0 master: pops one word per frame from a tx fifo, shifts it out MSB-first
// while shifting miso in, and writes the received word to an rx fifo.
module spi_word_xfer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CLKDIV = 2,
    parameter int unsigned GAP    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             empty,
    output logic             rd,
    output logic [WIDTH-1:0] rxd,
    output logic             rxwr,
    input  logic             rxfull,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             ss_n,
    output logic             busy
);

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StGap} state_e;

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] BitsAll = BW'(WIDTH);
    localparam logic [GW-1:0] GapLast = GW'(GAP - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [GW-1:0]    gapcnt_q, gapcnt_d;
    logic [WIDTH-1:0] rxd_d;
    logic             ss_n_d, sclk_d, mosi_d, rd_d, rxwr_d, busy_d;
    logic             clr, tick;

    spi_tick #(
        .CLKDIV (CLKDIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        ss_n_d   = ss_n;
        sclk_d   = sclk;
        mosi_d   = mosi;
        rd_d     = 1'b0;
        rxwr_d   = 1'b0;
        rxd_d    = rxd;
        clr      = 1'b0;

        case (state_q)
            StIdle: begin
                clr = 1'b1;
                if (!empty && !rxfull) begin
                    tx_d     = d;
                    rd_d     = 1'b1;
                    ss_n_d   = 1'b0;
                    mosi_d   = d[WIDTH-1];
                    bitcnt_d = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    sclk_d   = 1'b1;
                    rx_d     = {rx_q[WIDTH-2:0], miso};
                    bitcnt_d = bitcnt_q + BW'(1);
                    state_d  = StHigh;
                end
            end
            StHigh: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    state_d = StLow;
                    // Leave mosi on the last bit once all rising edges are done.
                    if (bitcnt_q < BitsAll) begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[WIDTH-2];
                    end
                end
            end
            StLow: begin
                if (tick) begin
                    if (bitcnt_q < BitsAll) begin
                        sclk_d   = 1'b1;
                        rx_d     = {rx_q[WIDTH-2:0], miso};
                        bitcnt_d = bitcnt_q + BW'(1);
                        state_d  = StHigh;
                    end else begin
                        ss_n_d   = 1'b1;
                        rxwr_d   = 1'b1;
                        rxd_d    = rx_q;
                        mosi_d   = 1'b0;
                        gapcnt_d = '0;
                        state_d  = StGap;
                    end
                end
            end
            StGap: begin
                clr = 1'b1;
                if (gapcnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gapcnt_d = gapcnt_q + GW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tx_q     <= '0;
            rx_q     <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            ss_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            rd       <= 1'b0;
            rxwr     <= 1'b0;
            rxd      <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            ss_n     <= ss_n_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
            rd       <= rd_d;
            rxwr     <= rxwr_d;
            rxd      <= rxd_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_word_xfer.sv
// Directed bench for spi_word_xfer: a 16-bit/CLKDIV=2 instance and an 8-bit/CLKDIV=1
// instance, both with miso looped back to mosi and a small tx fifo model.
module tb_spi_word_xfer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic [15:0] d16, rxd16;
    logic        empty16, rd16, rxwr16, rxfull16, sclk16, mosi16, ss_n16, busy16;
    logic [15:0] mem16 [8];
    int          head16 = 0;
    int          tail16 = 0;

    assign d16     = mem16[head16 % 8];
    assign empty16 = (head16 == tail16);
    always @(posedge clk) if (rd16) head16 <= head16 + 1;

    spi_word_xfer #(
        .WIDTH  (16),
        .CLKDIV (2),
        .GAP    (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d16),
        .empty  (empty16),
        .rd     (rd16),
        .rxd    (rxd16),
        .rxwr   (rxwr16),
        .rxfull (rxfull16),
        .sclk   (sclk16),
        .mosi   (mosi16),
        .miso   (mosi16),
        .ss_n   (ss_n16),
        .busy   (busy16)
    );

    // 8-bit instance
    logic [7:0] d8, rxd8;
    logic       empty8, rd8, rxwr8, rxfull8, sclk8, mosi8, ss_n8, busy8;
    logic [7:0] mem8 [4];
    int         head8 = 0;
    int         tail8 = 0;

    assign d8     = mem8[head8 % 4];
    assign empty8 = (head8 == tail8);
    always @(posedge clk) if (rd8) head8 <= head8 + 1;

    spi_word_xfer #(
        .WIDTH  (8),
        .CLKDIV (1),
        .GAP    (1)
    ) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d8),
        .empty  (empty8),
        .rd     (rd8),
        .rxd    (rxd8),
        .rxwr   (rxwr8),
        .rxfull (rxfull8),
        .sclk   (sclk8),
        .mosi   (mosi8),
        .miso   (mosi8),
        .ss_n   (ss_n8),
        .busy   (busy8)
    );

    // Negedge monitors; the test process only reads these at posedge+1.
    int          cyc = 0;
    int          rd_cnt16 = 0, rxwr_cnt16 = 0, nbits16 = 0;
    int          last_rd16 = 0, prev_rd16 = 0;
    int          lo_run16 = 0, hi_run16 = 0, last_lo16 = 0, last_hi16 = 0;
    int          sync_bad16 = 0, rd_empty_bad16 = 0;
    logic [15:0] bits16 = '0;
    logic [15:0] rx_log16 [8];
    logic        rd_prev16 = 1'b0, sclk_prev16 = 1'b0, ss_prev16 = 1'b1, rxwr_prev16 = 1'b0;

    int          rd_cnt8 = 0, rxwr_cnt8 = 0, nbits8 = 0;
    int          lo_run8 = 0, last_lo8 = 0, last_rise8 = -1, rise_per8 = 0;
    logic [7:0]  bits8 = '0;
    logic        sclk_prev8 = 1'b0, ss_prev8 = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rd16) begin
            rd_cnt16  = rd_cnt16 + 1;
            prev_rd16 = last_rd16;
            last_rd16 = cyc;
            if (empty16) rd_empty_bad16 = rd_empty_bad16 + 1;
        end
        // rd and the ss_n fall must coincide, and both strobes last one cycle.
        if ((rd16 && rd_prev16) || (rxwr16 && rxwr_prev16)) sync_bad16 = sync_bad16 + 1;
        if (rd16 != (!ss_n16 && ss_prev16)) sync_bad16 = sync_bad16 + 1;
        if (rxwr16) begin
            rx_log16[rxwr_cnt16 % 8] = rxd16;
            rxwr_cnt16 = rxwr_cnt16 + 1;
        end
        if (sclk16 && !sclk_prev16) begin
            bits16  = {bits16[14:0], mosi16};
            nbits16 = nbits16 + 1;
        end
        if (!ss_n16) begin
            if (ss_prev16) last_hi16 = hi_run16;
            lo_run16 = lo_run16 + 1;
            hi_run16 = 0;
        end else begin
            if (!ss_prev16) last_lo16 = lo_run16;
            hi_run16 = hi_run16 + 1;
            lo_run16 = 0;
        end
        rd_prev16   = rd16;
        rxwr_prev16 = rxwr16;
        sclk_prev16 = sclk16;
        ss_prev16   = ss_n16;

        if (rd8) rd_cnt8 = rd_cnt8 + 1;
        if (rxwr8) rxwr_cnt8 = rxwr_cnt8 + 1;
        if (sclk8 && !sclk_prev8) begin
            bits8  = {bits8[6:0], mosi8};
            nbits8 = nbits8 + 1;
            if (last_rise8 >= 0) rise_per8 = cyc - last_rise8;
            last_rise8 = cyc;
        end
        if (!ss_n8) begin
            lo_run8 = lo_run8 + 1;
        end else begin
            if (!ss_prev8) last_lo8 = lo_run8;
            lo_run8 = 0;
        end
        sclk_prev8 = sclk8;
        ss_prev8   = ss_n8;
    end

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (act !== exp) begin
            miss_cnt = miss_cnt + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx16(input int target, input string name);
        int n;
        n = 0;
        while (rxwr_cnt16 < target && n < 400) begin
            step();
            n = n + 1;
        end
        chk(name, 32'(rxwr_cnt16 >= target), 32'd1);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_bits;
        logic [15:0] exp_rxd;
    } vec_t;

    vec_t tab [3];
    int   rd0, nb0, rx0, n;
    logic stay_hi;

    initial begin
        tab[0] = '{16'hA5C3, 16'b1010_0101_1100_0011, 16'hA5C3};
        tab[1] = '{16'h5A5A, 16'b0101_1010_0101_1010, 16'h5A5A};
        tab[2] = '{16'hFFFE, 16'b1111_1111_1111_1110, 16'hFFFE};

        rxfull16 = 1'b0;
        rxfull8  = 1'b0;
        rst_n    = 1'b0;
        repeat (3) step();
        chk("reset ss_n",  32'(ss_n16), 32'd1);
        chk("reset sclk",  32'(sclk16), 32'd0);
        chk("reset mosi",  32'(mosi16), 32'd0);
        chk("reset rd",    32'(rd16),   32'd0);
        chk("reset rxwr",  32'(rxwr16), 32'd0);
        chk("reset busy",  32'(busy16), 32'd0);
        chk("reset rxd",   32'(rxd16),  32'd0);
        chk("reset ss_n8", 32'(ss_n8),  32'd1);
        rst_n = 1'b1;
        repeat (2) step();

        // Single-word frames from the table.
        for (int i = 0; i < 3; i++) begin
            rd0 = rd_cnt16;
            nb0 = nbits16;
            rx0 = rxwr_cnt16;
            mem16[tail16 % 8] = tab[i].word;
            tail16 = tail16 + 1;
            repeat (10) step();
            chk($sformatf("vec%0d busy", i), 32'(busy16), 32'd1);
            wait_rx16(rx0 + 1, $sformatf("vec%0d rxwr seen", i));
            chk($sformatf("vec%0d rd pulses", i), 32'(rd_cnt16 - rd0), 32'd1);
            chk($sformatf("vec%0d sclk rises", i), 32'(nbits16 - nb0), 32'd16);
            chk($sformatf("vec%0d mosi bits", i), 32'(bits16), 32'(tab[i].exp_bits));
            chk($sformatf("vec%0d ss_n low", i), 32'(last_lo16), 32'd66);
            chk($sformatf("vec%0d rxd", i), 32'(rxd16), 32'(tab[i].exp_rxd));
            repeat (5) step();
            chk($sformatf("vec%0d idle busy", i), 32'(busy16), 32'd0);
        end

        // Back-to-back pair.
        rx0 = rxwr_cnt16;
        mem16[tail16 % 8] = 16'h0001;
        tail16 = tail16 + 1;
        mem16[tail16 % 8] = 16'h8000;
        tail16 = tail16 + 1;
        wait_rx16(rx0 + 2, "b2b rxwr seen");
        chk("b2b rxd first",  32'(rx_log16[rx0 % 8]),       32'h0001);
        chk("b2b rxd second", 32'(rx_log16[(rx0 + 1) % 8]), 32'h8000);
        chk("b2b rd spacing", 32'(last_rd16 - prev_rd16),   32'd69);
        chk("b2b ss_n gap",   32'(last_hi16),               32'd3);

        // Flow control: rx fifo full holds off the frame.
        rxfull16 = 1'b1;
        rd0 = rd_cnt16;
        rx0 = rxwr_cnt16;
        mem16[tail16 % 8] = 16'h3C96;
        tail16 = tail16 + 1;
        stay_hi = 1'b1;
        repeat (20) begin
            step();
            if (!ss_n16) stay_hi = 1'b0;
        end
        chk("flow no rd",     32'(rd_cnt16 - rd0), 32'd0);
        chk("flow ss_n high", 32'(stay_hi),        32'd1);
        rxfull16 = 1'b0;
        step();
        chk("flow rd",   32'(rd16),   32'd1);
        chk("flow ss_n", 32'(ss_n16), 32'd0);
        wait_rx16(rx0 + 1, "flow rxwr seen");
        chk("flow rxd", 32'(rxd16), 32'h3C96);

        // Reset in the middle of a frame.
        repeat (6) step();
        rx0 = rxwr_cnt16;
        nb0 = nbits16;
        mem16[tail16 % 8] = 16'h1234;
        tail16 = tail16 + 1;
        mem16[tail16 % 8] = 16'hC0DE;
        tail16 = tail16 + 1;
        n = 0;
        while (nbits16 < nb0 + 8 && n < 400) begin
            step();
            n = n + 1;
        end
        chk("abort reached 8 rises", 32'(nbits16 >= nb0 + 8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort ss_n", 32'(ss_n16), 32'd1);
        chk("abort sclk", 32'(sclk16), 32'd0);
        chk("abort busy", 32'(busy16), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        nb0 = nbits16;
        wait_rx16(rx0 + 1, "abort next rxwr seen");
        chk("abort next rxd",  32'(rxd16),           32'hC0DE);
        chk("abort next bits", 32'(bits16),          32'hC0DE);
        chk("abort next rises", 32'(nbits16 - nb0),  32'd16);
        repeat (80) step();
        chk("abort one rxwr",  32'(rxwr_cnt16 - rx0), 32'd1);
        chk("abort fifo empty", 32'(empty16),         32'd1);

        // 8-bit, CLKDIV=1, GAP=1 instance.
        rd0 = rd_cnt8;
        rx0 = rxwr_cnt8;
        nb0 = nbits8;
        mem8[tail8 % 4] = 8'h3C;
        tail8 = tail8 + 1;
        n = 0;
        while (rxwr_cnt8 < rx0 + 1 && n < 200) begin
            step();
            n = n + 1;
        end
        chk("w8 rxwr seen",   32'(rxwr_cnt8 - rx0), 32'd1);
        chk("w8 rd pulses",   32'(rd_cnt8 - rd0),   32'd1);
        chk("w8 sclk rises",  32'(nbits8 - nb0),    32'd8);
        chk("w8 mosi bits",   32'(bits8),           32'b0011_1100);
        chk("w8 sclk period", 32'(rise_per8),       32'd2);
        chk("w8 ss_n low",    32'(last_lo8),        32'd17);
        chk("w8 rxd",         32'(rxd8),            32'h3C);

        chk("rd/ss_n/strobe sync", 32'(sync_bad16),     32'd0);
        chk("rd while empty",      32'(rd_empty_bad16), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
